vram_uart_dump: RTL and testbench



---
 rtl/vram_uart_dump.sv | 161 ++++++++++++++++
 tb/tb_vram_uart_dump.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_uart_dump.sv
// vram_uart_dump: reads rows of the character buffer through a spare RAM read
// port and streams them to a UART byte interface. Trailing blanks are trimmed,
// non-printables are shown as '.', and every row ends with CR LF.
module vram_uart_dump #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  start_row,
  input  logic [5:0]  num_rows,
  output logic        rd_en,
  output logic [11:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] COLS_L  = 8'(COLS);
  localparam logic [5:0] ROWS_L  = 6'(ROWS);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_FETCH, S_SEND, S_CR, S_LF, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  row;
  logic [5:0]  left;
  logic [5:0]  left_init;
  logic [6:0]  col;
  logic [7:0]  last, last_nxt;
  logic [7:0]  scan_cnt;
  logic        first_p1;
  logic [7:0]  hold_p1;

  function automatic logic is_blank(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'h20);
  endfunction

  function automatic logic [7:0] map_byte(input logic [7:0] c);
    if (c == 8'h00)                      return 8'h20;
    else if (c >= 8'h20 && c <= 8'h7E)   return c;
    else                                 return 8'h2E;
  endfunction

  assign left_init = (num_rows > ROWS_L) ? ROWS_L : num_rows;

  // Running position of the last non-blank column seen while scanning.
  // Data for column scan_cnt-1 arrives while scan_cnt is being held.
  always_comb begin
    last_nxt = last;
    if (state == S_SCAN && scan_cnt != 8'd0 && !is_blank(rd_data))
      last_nxt = scan_cnt;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (left_init == 6'd0) ? S_NEXT : S_SCAN;
      S_SCAN:  if (scan_cnt == COLS_L) state_nxt = (last_nxt == 8'd0) ? S_CR : S_FETCH;
      S_FETCH: state_nxt = S_SEND;
      S_SEND:  if (tx_ready) state_nxt = (({1'b0, col} + 8'd1) == last) ? S_CR : S_FETCH;
      S_CR:    if (tx_ready) state_nxt = S_LF;
      S_LF:    if (tx_ready) state_nxt = S_NEXT;
      // An empty request also passes through NEXT so done lands two cycles
      // after acceptance; left saturates at zero there.
      S_NEXT:  state_nxt = (left <= 6'd1) ? S_DONE : S_SCAN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row, column and scan bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= 5'd0;
      left     <= 6'd0;
      col      <= 7'd0;
      last     <= 8'd0;
      scan_cnt <= 8'd0;
      first_p1 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          row      <= start_row;
          left     <= left_init;
          scan_cnt <= 8'd0;
          last     <= 8'd0;
        end
        S_SCAN: begin
          scan_cnt <= scan_cnt + 8'd1;
          last     <= last_nxt;
          if (scan_cnt == COLS_L) col <= 7'd0;
        end
        S_FETCH: first_p1 <= 1'b1;
        S_SEND: begin
          first_p1 <= 1'b0;
          if (tx_ready) col <= col + 7'd1;
        end
        S_NEXT: begin
          left     <= (left == 6'd0) ? 6'd0 : left - 6'd1;
          row      <= (row == ROW_MAX) ? 5'd0 : row + 5'd1;
          scan_cnt <= 8'd0;
          last     <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Capture the mapped byte on the cycle its read data returns.
  always_ff @(posedge clk) begin
    if (state == S_SEND && first_p1) hold_p1 <= map_byte(rd_data);
  end

  // Output decode from state.
  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = 12'd0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != S_IDLE) && (state != S_DONE);
    done     = (state == S_DONE);
    case (state)
      S_SCAN: if (scan_cnt < COLS_L) begin
        rd_en   = 1'b1;
        rd_addr = {row, scan_cnt[6:0]};
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = {row, col};
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = first_p1 ? map_byte(rd_data) : hold_p1;
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_uart_dump.sv
// Bench for vram_uart_dump: character RAM model, byte monitor and a
// row-at-a-time reference model of the dump stream.
module tb_vram_uart_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  start_row;
  logic [5:0]  num_rows;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [32][128];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int rd_cnt = 0, done_cnt = 0, stab_err = 0, rd_err = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_data = 8'h00;

  vram_uart_dump #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_row(start_row),
    .num_rows(num_rows), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Character RAM: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[11:7]][rd_addr[6:0]];
  end

  // Monitor: accepted bytes, read strobes, done pulses, handshake stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend && (!tx_valid || tx_data != pend_data)) stab_err++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (rd_en) rd_cnt++;
      if (rd_en && !busy) rd_err++;
      if (done) done_cnt++;
      pend      = tx_valid && !tx_ready;
      pend_data = tx_data;
    end
  end

  // Reference: trimmed, mapped rows with CR LF, rows wrapping modulo 30.
  task automatic model(input int sr, input int nr, output int rdexp);
    int n, r, len;
    logic [7:0] b;
    n = (nr > 30) ? 30 : nr;
    r = sr;
    rdexp = 0;
    for (int k = 0; k < n; k++) begin
      len = 0;
      for (int c = 0; c < 80; c++)
        if (mem[r][c] != 8'h00 && mem[r][c] != 8'h20) len = c + 1;
      for (int c = 0; c < len; c++) begin
        b = mem[r][c];
        if (b == 8'h00) exp_q.push_back(8'h20);
        else if (b >= 8'h20 && b <= 8'h7E) exp_q.push_back(b);
        else exp_q.push_back(8'h2E);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      rdexp += 80 + len;
      r = (r + 1) % 30;
    end
  endtask

  task automatic fill_row(input int r, input int len);
    logic [7:0] v;
    for (int c = 0; c < 128; c++) begin
      if (c < len - 1) v = 8'($urandom_range(0, 255));
      else if (c == len - 1) begin
        v = 8'($urandom_range(1, 255));
        if (v == 8'h20) v = 8'h41;
      end else v = $urandom_range(0, 1) ? 8'h20 : 8'h00;
      mem[r][c] = v;
    end
  endtask

  // Launch one dump; mode 0 holds tx_ready high, mode 1 randomizes it.
  // inject >= 0 pulses a stray start with random arguments on that cycle.
  task automatic run_dump(input int sr, input int nr, input int mode, input int inject,
                          output logic b0, output logic r0, output logic [11:0] a0,
                          output bit timed_out);
    @(posedge clk); #1;
    start = 1'b1; start_row = 5'(sr); num_rows = 6'(nr); tx_ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0; start_row = 5'($urandom); num_rows = 6'($urandom);
    b0 = busy; r0 = rd_en; a0 = rd_addr;
    timed_out = 1'b1;
    for (int i = 0; i < 40000; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == inject) begin
        start = 1'b1; start_row = 5'($urandom_range(0, 29)); num_rows = 6'($urandom_range(0, 63));
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0; start_row = 5'd0; num_rows = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (rd_en !== 1'b0)     begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    total++; if (rd_addr !== 12'd0)  begin bad++; $display("FAIL reset_rd_addr got=%h want=000", rd_addr); end
    total++; if (tx_data !== 8'h00)  begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    total++; if (tx_valid !== 1'b0)  begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int g0, r0c, d0, rdexp;
    logic b0, e0; logic [11:0] a0; bit to;
    for (int c = 0; c < 128; c++) mem[0][c] = 8'h20;
    mem[0][0] = 8'h41; mem[0][1] = 8'h42;
    exp_q.delete(); model(0, 1, rdexp);
    g0 = got_q.size(); r0c = rd_cnt; d0 = done_cnt;
    run_dump(0, 1, 0, -1, b0, e0, a0, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout"); end
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start got=%b want=1", b0); end
    total++; if (e0 !== 1'b1 || a0 !== 12'h000) begin bad++; $display("FAIL basic_first_read got=%b/%h want=1/000", e0, a0); end
    total++; if (got_q.size() - g0 != 4) begin bad++; $display("FAIL basic_len got=%0d want=4", got_q.size() - g0); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, got_q[g0+i], exp_q[i]); end
    end
    total++; if (rd_cnt - r0c != 82) begin bad++; $display("FAIL basic_rd_en got=%0d want=82", rd_cnt - r0c); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_blank();
    int g0, r0c, rdexp;
    logic b0, e0; logic [11:0] a0; bit to;
    for (int c = 0; c < 128; c++) mem[7][c] = (c % 3 == 0) ? 8'h00 : 8'h20;
    exp_q.delete(); model(7, 1, rdexp);
    g0 = got_q.size(); r0c = rd_cnt;
    run_dump(7, 1, 1, -1, b0, e0, a0, to);
    total++; if (to) begin bad++; $display("FAIL blank_timeout"); end
    total++; if (e0 !== 1'b1 || a0 !== {5'd7, 7'd0}) begin bad++; $display("FAIL blank_first_read got=%b/%h want=1/%h", e0, a0, {5'd7, 7'd0}); end
    total++; if (got_q.size() - g0 != 2) begin bad++; $display("FAIL blank_len got=%0d want=2", got_q.size() - g0); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL blank_byte%0d got=%h want=%h", i, got_q[g0+i], exp_q[i]); end
    end
    total++; if (rd_cnt - r0c != 80) begin bad++; $display("FAIL blank_rd_en got=%0d want=80", rd_cnt - r0c); end
  endtask

  task automatic test_mapping();
    int g0, rdexp;
    logic b0, e0; logic [11:0] a0; bit to;
    logic [7:0] want [6];
    want = '{8'h2E, 8'h20, 8'h41, 8'h2E, 8'h0D, 8'h0A};
    for (int c = 0; c < 128; c++) mem[2][c] = 8'h00;
    mem[2][0] = 8'h7F; mem[2][1] = 8'h00; mem[2][2] = 8'h41; mem[2][3] = 8'h09;
    g0 = got_q.size();
    run_dump(2, 1, 1, -1, b0, e0, a0, to);
    total++; if (to) begin bad++; $display("FAIL map_timeout"); end
    total++; if (got_q.size() - g0 != 6) begin bad++; $display("FAIL map_len got=%0d want=6", got_q.size() - g0); end
    for (int i = 0; i < 6 && g0 + i < got_q.size(); i++) begin
      total++; if (got_q[g0+i] !== want[i]) begin bad++; $display("FAIL map_byte%0d got=%h want=%h", i, got_q[g0+i], want[i]); end
    end
  endtask

  task automatic test_backpressure();
    int g0, n58;
    bit seen, fin;
    for (int c = 0; c < 128; c++) mem[4][c] = 8'h20;
    mem[4][0] = 8'h58;
    g0 = got_q.size();
    @(posedge clk); #1;
    start = 1'b1; start_row = 5'd4; num_rows = 6'd1; tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_valid_timeout"); end
    for (int k = 0; k < 10; k++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'h58) begin bad++; $display("FAIL bp_hold%0d got=%b/%h want=1/58", k, tx_valid, tx_data); end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin fin = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++; if (!fin) begin bad++; $display("FAIL bp_done_timeout"); end
    @(posedge clk); #1;
    n58 = 0;
    for (int i = g0; i < got_q.size(); i++) if (got_q[i] == 8'h58) n58++;
    total++; if (n58 != 1) begin bad++; $display("FAIL bp_count got=%0d want=1", n58); end
    total++; if (got_q.size() - g0 != 3) begin bad++; $display("FAIL bp_len got=%0d want=3", got_q.size() - g0); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stability got=%0d want=0", stab_err); end
  endtask

  task automatic test_zero_rows();
    int g0, r0c;
    g0 = got_q.size(); r0c = rd_cnt;
    @(posedge clk); #1;
    start = 1'b1; start_row = 5'd3; num_rows = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL zero_n1 got=%b/%b want=1/0", busy, done); end
    @(posedge clk); #1;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_n2 got=%b/%b want=1/0", done, busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
    total++; if (rd_cnt != r0c || got_q.size() != g0) begin bad++; $display("FAIL zero_traffic got=%0d/%0d want=0/0", rd_cnt - r0c, got_q.size() - g0); end
  endtask

  task automatic test_wrap_clamp();
    int g0, r0c, rdexp, ncr;
    logic b0, e0; logic [11:0] a0; bit to;
    for (int r = 0; r < 30; r++) fill_row(r, $urandom_range(0, 12));
    exp_q.delete(); model(29, 40, rdexp);
    g0 = got_q.size(); r0c = rd_cnt;
    run_dump(29, 40, 1, -1, b0, e0, a0, to);
    total++; if (to) begin bad++; $display("FAIL wrap_timeout"); end
    total++; if (a0 !== {5'd29, 7'd0}) begin bad++; $display("FAIL wrap_first_addr got=%h want=%h", a0, {5'd29, 7'd0}); end
    total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL wrap_len got=%0d want=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      if (got_q[g0+i] !== exp_q[i]) begin
        total++; bad++; $display("FAIL wrap_byte%0d got=%h want=%h", i, got_q[g0+i], exp_q[i]); break;
      end
    end
    ncr = 0;
    for (int i = g0; i + 1 < got_q.size(); i++) if (got_q[i] == 8'h0D && got_q[i+1] == 8'h0A) ncr++;
    total++; if (ncr != 30) begin bad++; $display("FAIL wrap_crlf got=%0d want=30", ncr); end
    total++; if (rd_cnt - r0c != rdexp) begin bad++; $display("FAIL wrap_rd_en got=%0d want=%0d", rd_cnt - r0c, rdexp); end
  endtask

  task automatic test_back_to_back();
    int g0, r0c, rdexp, sr, nr;
    logic b0, e0; logic [11:0] a0; bit to;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 30; r++) fill_row(r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 6));
      sr = $urandom_range(0, 29); nr = $urandom_range(0, 5);
      exp_q.delete(); model(sr, nr, rdexp);
      g0 = got_q.size(); r0c = rd_cnt;
      run_dump(sr, nr, t % 2, (nr == 0) ? -1 : $urandom_range(0, 60), b0, e0, a0, to);
      total++; if (to) begin bad++; $display("FAIL b2b%0d_timeout", t); end
      total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL b2b%0d_len got=%0d want=%0d", t, got_q.size() - g0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
        if (got_q[g0+i] !== exp_q[i]) begin
          total++; bad++; $display("FAIL b2b%0d_byte%0d got=%h want=%h", t, i, got_q[g0+i], exp_q[i]); break;
        end
      end
      total++; if (rd_cnt - r0c != rdexp) begin bad++; $display("FAIL b2b%0d_rd_en got=%0d want=%0d", t, rd_cnt - r0c, rdexp); end
    end
  endtask

  task automatic test_reset_mid();
    int g0, rdexp;
    logic b0, e0; logic [11:0] a0; bit to, seen;
    fill_row(3, 5); fill_row(4, 2);
    @(posedge clk); #1;
    start = 1'b1; start_row = 5'd3; num_rows = 6'd2; tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstmid_valid_timeout"); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0)
      begin bad++; $display("FAIL rstmid_async got=%b%b%b%b want=0000", tx_valid, busy, done, rd_en); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); model(3, 2, rdexp);
    g0 = got_q.size();
    run_dump(3, 2, 1, -1, b0, e0, a0, to);
    total++; if (to) begin bad++; $display("FAIL rstmid_timeout"); end
    total++; if (a0 !== {5'd3, 7'd0}) begin bad++; $display("FAIL rstmid_first_addr got=%h want=%h", a0, {5'd3, 7'd0}); end
    total++; if (got_q.size() - g0 != exp_q.size()) begin bad++; $display("FAIL rstmid_len got=%0d want=%0d", got_q.size() - g0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      total++; if (got_q[g0+i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, got_q[g0+i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 128; c++) mem[r][c] = 8'h00;
    test_reset();
    test_basic();
    test_blank();
    test_mapping();
    test_backpressure();
    test_zero_rows();
    test_wrap_clamp();
    test_back_to_back();
    test_reset_mid();
    total++; if (stab_err != 0) begin bad++; $display("FAIL tx_stability got=%0d want=0", stab_err); end
    total++; if (rd_err != 0) begin bad++; $display("FAIL rd_en_while_idle got=%0d want=0", rd_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
